// File: rtl/isqrt_seq.sv
// Sequential integer square root: floor(sqrt(x)) and remainder x - root^2.
// Digit-by-digit restoring algorithm, one root bit per clock.
// Valid/ready handshake on both sides; all outputs come straight from flops.

module isqrt_seq #(
    parameter int DATA_W = 10,
    parameter int ROOT_W = DATA_W / 2,
    parameter int REM_W  = DATA_W / 2 + 1
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [DATA_W-1:0] in_data,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [ROOT_W-1:0] out_root,
    output logic [REM_W-1:0]  out_rem,
    output logic              out_exact,
    output logic              busy
);

    // The radicand is consumed two bits at a time, so it must have an even width.
    generate
        if ((DATA_W % 2) != 0 || DATA_W < 2) begin : g_bad_data_w
            $error("isqrt_seq: DATA_W must be even and >= 2");
        end
        if (ROOT_W != DATA_W / 2 || REM_W != DATA_W / 2 + 1) begin : g_bad_derived
            $error("isqrt_seq: ROOT_W and REM_W are derived from DATA_W and must not be overridden");
        end
    endgenerate

    localparam int CNT_W = $clog2(ROOT_W + 1);
    // One extra bit above t's REM_W+2 bits holds the borrow of the trial subtraction.
    localparam int SUB_W = REM_W + 3;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        CALC = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t            state;
    logic [DATA_W-1:0] shift_q;
    logic [CNT_W-1:0]  count_q;
    logic [ROOT_W-1:0] root_q;
    logic [REM_W-1:0]  rem_q;

    logic [SUB_W-1:0]  t_ext;
    logic [SUB_W-1:0]  trial;
    logic [SUB_W-1:0]  diff;
    logic              borrow;
    logic [ROOT_W-1:0] root_nxt;
    logic [REM_W-1:0]  rem_nxt;

    // One restoring iteration: bring down the next bit pair and try subtracting 4*root+1.
    always_comb begin
        // NOTE: every always_comb output gets a default first so no path can infer a latch.
        t_ext    = '0;
        trial    = '0;
        diff     = '0;
        borrow   = 1'b0;
        root_nxt = '0;
        rem_nxt  = '0;

        t_ext    = {1'b0, rem_q, shift_q[DATA_W-1 -: 2]};
        trial    = {2'b00, root_q, 2'b01};
        diff     = t_ext - trial;
        borrow   = diff[SUB_W-1];
        // Remainder stays <= 2*root, so both candidates fit REM_W bits; the root MSB shifted
        // out is always zero because the root has at most ROOT_W significant bits.
        rem_nxt  = borrow ? t_ext[REM_W-1:0] : diff[REM_W-1:0];
        root_nxt = ROOT_W'({root_q, ~borrow});
    end

    // Control FSM together with the datapath registers and the registered outputs.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= IDLE;
            shift_q   <= '0;
            count_q   <= '0;
            root_q    <= '0;
            rem_q     <= '0;
            in_ready  <= 1'b1;
            out_valid <= 1'b0;
            busy      <= 1'b0;
            out_root  <= '0;
            out_rem   <= '0;
            out_exact <= 1'b0;
        end else begin
            // NOTE: state is updated with non-blocking assignments so every flop samples
            // pre-edge values, independent of statement order.
            case (state)
                IDLE: begin
                    if (in_valid && in_ready) begin
                        shift_q  <= in_data;
                        root_q   <= '0;
                        rem_q    <= '0;
                        count_q  <= CNT_W'(ROOT_W);
                        in_ready <= 1'b0;
                        busy     <= 1'b1;
                        state    <= CALC;
                    end
                end
                CALC: begin
                    shift_q <= shift_q << 2;
                    root_q  <= root_nxt;
                    rem_q   <= rem_nxt;
                    count_q <= count_q - CNT_W'(1);
                    // Last iteration: publish the result on the same edge it is formed.
                    if (count_q == CNT_W'(1)) begin
                        out_root  <= root_nxt;
                        out_rem   <= rem_nxt;
                        out_exact <= (rem_nxt == '0);
                        out_valid <= 1'b1;
                        state     <= DONE;
                    end
                end
                DONE: begin
                    if (out_valid && out_ready) begin
                        out_valid <= 1'b0;
                        in_ready  <= 1'b1;
                        busy      <= 1'b0;
                        state     <= IDLE;
                    end
                end
                default: begin
                    out_valid <= 1'b0;
                    in_ready  <= 1'b1;
                    busy      <= 1'b0;
                    state     <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_isqrt_seq.sv
// Self-checking bench for isqrt_seq: directed handshake/boundary cases, a reset abort,
// and a full sweep of the 10-bit input range with random output backpressure.
// Expected results come from a plain arithmetic square-root model.

module tb_isqrt_seq;

    localparam int DATA_W = 10;
    localparam int ROOT_W = DATA_W / 2;
    localparam int REM_W  = DATA_W / 2 + 1;

    logic              clk;
    logic              rst_n;
    logic              in_valid;
    logic              in_ready;
    logic [DATA_W-1:0] in_data;
    logic              out_valid;
    logic              out_ready;
    logic [ROOT_W-1:0] out_root;
    logic [REM_W-1:0]  out_rem;
    logic              out_exact;
    logic              busy;

    int vectors     = 0;
    int miscompares = 0;

    isqrt_seq #(.DATA_W(DATA_W)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_data   (in_data),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_root  (out_root),
        .out_rem   (out_rem),
        .out_exact (out_exact),
        .busy      (busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Reference: largest r with r*r <= x, found by counting up.
    function automatic int ref_root(input int x);
        int r;
        r = 0;
        while ((r + 1) * (r + 1) <= x) r++;
        return r;
    endfunction

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Present x until the unit takes it; returns just after the accept edge.
    task automatic send(input int x);
        int guard;
        guard    = 0;
        in_data  = DATA_W'(x);
        in_valid = 1'b1;
        while (!in_ready && guard < 100) begin
            tick();
            guard++;
        end
        if (guard >= 100) check("send_timeout", 1, 0);
        tick();
        in_valid = 1'b0;
    endtask

    // Count edges after the accept edge until out_valid is seen, bounded.
    task automatic wait_valid(input string tag, output int lat);
        lat = 0;
        while (!out_valid && lat < 50) begin
            tick();
            lat++;
        end
        if (!out_valid) check({tag, "_timeout"}, 0, 1);
    endtask

    // Full directed transaction with immediate consumption.
    task automatic run_one(input string tag, input int x);
        int lat;
        int r;
        r = ref_root(x);
        out_ready = 1'b0;
        send(x);
        wait_valid(tag, lat);
        check({tag, "_latency"}, lat, ROOT_W);
        check({tag, "_root"}, out_root, r);
        check({tag, "_rem"}, out_rem, x - r * r);
        check({tag, "_exact"}, out_exact, (x == r * r) ? 1 : 0);
        out_ready = 1'b1;
        tick();
        out_ready = 1'b0;
        check({tag, "_valid_drop"}, out_valid, 0);
        check({tag, "_ready_back"}, in_ready, 1);
    endtask

    initial begin
        int lat;
        int r;
        int got_root;
        int got_rem;
        int guard;

        rst_n     = 1'b0;
        in_valid  = 1'b0;
        in_data   = '0;
        out_ready = 1'b0;
        repeat (2) tick();
        check("rst_out_valid", out_valid, 0);
        check("rst_in_ready", in_ready, 1);
        check("rst_busy", busy, 0);
        check("rst_root", out_root, 0);
        check("rst_rem", out_rem, 0);
        check("rst_exact", out_exact, 0);
        @(negedge clk);
        rst_n = 1'b1;
        tick();

        // x = 0 with out_ready already high.
        out_ready = 1'b1;
        send(0);
        wait_valid("zero", lat);
        check("zero_latency", lat, 5);
        check("zero_root", out_root, 0);
        check("zero_rem", out_rem, 0);
        check("zero_exact", out_exact, 1);
        check("zero_busy", busy, 1);
        tick();
        out_ready = 1'b0;
        check("zero_valid_drop", out_valid, 0);
        check("zero_ready_back", in_ready, 1);

        run_one("x961", 961);
        run_one("x1023", 1023);
        check("x1023_root_max", out_root, 31);
        check("x1023_rem_max", out_rem, 62);
        run_one("x24", 24);

        // Backpressure: result held stable for 20 cycles, new requests ignored.
        out_ready = 1'b0;
        send(100);
        wait_valid("bp", lat);
        in_data  = 10'd7;
        in_valid = 1'b1;
        for (int i = 0; i < 20; i++) begin
            check("bp_valid", out_valid, 1);
            check("bp_root", out_root, 10);
            check("bp_rem", out_rem, 0);
            check("bp_in_ready", in_ready, 0);
            tick();
        end
        in_valid  = 1'b0;
        out_ready = 1'b1;
        tick();
        out_ready = 1'b0;
        check("bp_valid_drop", out_valid, 0);
        repeat (8) tick();
        check("bp_no_queue_valid", out_valid, 0);
        check("bp_no_queue_busy", busy, 0);

        // Producer holds in_valid: 50 first, then 81 once the first result is taken.
        send(50);
        in_data  = 10'd81;
        in_valid = 1'b1;
        wait_valid("hold50", lat);
        check("hold50_root", out_root, 7);
        check("hold50_rem", out_rem, 1);
        check("hold50_exact", out_exact, 0);
        out_ready = 1'b1;
        tick();
        out_ready = 1'b0;
        check("hold_idle_ready", in_ready, 1);
        tick();
        in_valid = 1'b0;
        check("hold81_accepted", busy, 1);
        wait_valid("hold81", lat);
        check("hold81_latency", lat, 5);
        check("hold81_root", out_root, 9);
        check("hold81_rem", out_rem, 0);
        check("hold81_exact", out_exact, 1);
        out_ready = 1'b1;
        tick();
        out_ready = 1'b0;

        // Reset in the third CALC cycle of 500 aborts at once.
        send(500);
        tick();
        tick();
        rst_n = 1'b0;
        #1;
        check("abort_valid", out_valid, 0);
        check("abort_in_ready", in_ready, 1);
        check("abort_busy", busy, 0);
        check("abort_root", out_root, 0);
        @(negedge clk);
        rst_n = 1'b1;
        tick();
        run_one("after_abort144", 144);
        check("after_abort_root", out_root, 12);

        // Sweep the whole input range with random out_ready every cycle.
        for (int x = 0; x < (1 << DATA_W); x++) begin
            send(x);
            guard = 0;
            out_ready = 1'($urandom_range(0, 1));
            while (!(out_valid && out_ready) && guard < 100) begin
                tick();
                guard++;
                out_ready = 1'($urandom_range(0, 1));
            end
            if (guard >= 100) check("sweep_timeout", 0, 1);
            r        = ref_root(x);
            got_root = int'(out_root);
            got_rem  = int'(out_rem);
            check("sweep_root", got_root, r);
            check("sweep_identity", got_root * got_root + got_rem, x);
            check("sweep_rem_bound", (got_rem <= 2 * got_root) ? 1 : 0, 1);
            tick();
            out_ready = 1'b0;
            check("sweep_single_transfer", out_valid, 0);
        end

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule

// File: doc/isqrt_seq.md
Name: isqrt_seq

Overview:
- Sequential integer square-root unit: the inverse of the team's combinational squarer benchmarks.
- Accepts an unsigned DATA_W-bit value and returns floor(sqrt(x)) plus the remainder x - root².
- Uses a digit-by-digit, bit-pair restoring algorithm, one root bit per clock.
- Used as a training/benchmark block for power-aware synthesis, and as the checker partner for squarer outputs.

Parameters:
- DATA_W, 10, radicand width; must be even and >= 2 (elaboration error otherwise).
- ROOT_W, DATA_W/2, root width (derived; do not override).
- REM_W, DATA_W/2+1, remainder width (derived; do not override).

Ports:
- clk  in  1  clock; all state updates on the rising edge.
- rst_n  in  1  asynchronous reset, active-low.
- in_valid  in  1  radicand valid.
- in_ready  out  1  unit can accept a radicand.
- in_data  in  DATA_W  unsigned radicand.
- out_valid  out  1  result valid.
- out_ready  in  1  consumer accepts result.
- out_root  out  ROOT_W  floor(sqrt(in_data)).
- out_rem  out  REM_W  in_data - out_root²; range 0..2*out_root.
- out_exact  out  1  1 when out_rem == 0.
- busy  out  1  high in CALC or DONE.

Behaviour:
- Reset (async assert, sync release):
  - FSM goes to IDLE.
  - out_valid=0, in_ready=1, busy=0.
  - out_root=0, out_rem=0, out_exact=0.
  - Internal radicand shift register, iteration counter and accumulators cleared.
- FSM states: IDLE, CALC, DONE.
- IDLE:
  - in_ready=1.
  - On in_valid&&in_ready at an edge: latch in_data into the shift register, clear root and rem, load count=ROOT_W, go to CALC.
  - in_data is sampled only on this edge.
- CALC, one iteration per cycle (in_ready=0, out_valid=0):
  - t = (rem<<2) | top two bits of the shift register.
  - d = t - ((root<<2)|1), computed in REM_W+2 bits.
  - If d >= 0 (no borrow): rem = d, root = (root<<1)|1.
  - Else: rem = t, root = root<<1.
  - Shift register moves left by 2; count decrements.
  - After the iteration that brings count to 0, go to DONE.
  - The remainder always fits REM_W bits; the intermediate t needs REM_W+2 bits.
- DONE:
  - out_valid=1.
  - out_root, out_rem and out_exact are registered and held stable while out_valid=1 && out_ready=0 (backpressure of any length).
  - On out_valid&&out_ready: go to IDLE; out_valid drops next cycle. Output data may retain its last value.
- Latency:
  - Accept edge at cycle 0; out_valid is high from cycle ROOT_W onward (5 cycles at the default).
  - Throughput is one result per ROOT_W+2 cycles minimum, because in_ready=0 in CALC and DONE.
  - No overlap of accept and deliver.
- Handshake rules:
  - in_valid while in_ready=0 is ignored and not queued.
  - A producer may hold in_valid high; the next transfer occurs on the first IDLE cycle.
  - out_ready while out_valid=0 has no effect.
- Boundary conditions:
  - x=0 gives root=0, rem=0, exact=1.
  - x=2^DATA_W-1 gives root=2^ROOT_W-1, rem=2^(ROOT_W+1)-2.
  - Perfect squares give exact=1.
  - Reset asserted in CALC or DONE aborts immediately: outputs take reset values and the result is discarded.
- Outputs are driven from flops only; no combinational path from inputs to outputs except through state.

Test Plan:
- in_data=0, out_ready=1 -> out_valid rises 5 cycles after accept; root=0, rem=0, exact=1; in_ready back to 1 one cycle after the transfer.
- in_data=961 -> root=31, rem=0, exact=1. in_data=1023 -> root=31, rem=62, exact=0. in_data=24 -> root=4, rem=8, exact=0.
- in_data=100 with out_ready held 0 for 20 cycles -> out_valid stays 1 and root=10, rem=0 stable throughout; in_ready=0 and a second in_valid is ignored; transfer completes when out_ready=1.
- in_valid held high with values 50 then 81 -> 50 accepted first, giving 7/1; 81 accepted only after the first result transfers, giving 9/0/exact.
- rst_n pulsed low in the 3rd CALC cycle of in_data=500 -> out_valid=0 and in_ready=1 immediately; a new 144 afterwards gives 12/0 with no corruption.
- Exhaustive sweep of 0..1023 with random out_ready -> root²+rem==x and rem<=2*root for every result, with no dropped or duplicated transfers.
